// File: rtl/nonce_job_ctrl.sv
// Job sequencer for one heavy-hash mining lane: loads the target into the comparator,
// issues a nonce range to the pipeline and reports the golden nonce or range exhaustion.
module nonce_job_ctrl #(
    parameter int unsigned INFLIGHT_DEPTH = 64,
    parameter int unsigned CNT_W          = $clog2(INFLIGHT_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_target,
    input  logic [63:0]  job_nonce_start,
    input  logic [63:0]  job_nonce_end,
    input  logic         abort,
    output logic [31:0]  target_word,
    output logic         comp_start,
    output logic         comp_stop,
    input  logic         comp_stop_ack,
    input  logic         comp_result,
    input  logic         hash_pop,
    output logic [63:0]  nonce_out,
    output logic         nonce_valid,
    input  logic         nonce_ready,
    output logic         found_valid,
    output logic [63:0]  found_nonce,
    output logic         exhausted,
    output logic         busy,
    output logic         err_underflow
);

    localparam int unsigned      PTR_W   = $clog2(INFLIGHT_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(INFLIGHT_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_STOPPING = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [255:0]     r_target;
    logic [63:0]      r_end;
    logic [63:0]      r_cur;
    logic             r_empty_range;
    logic [2:0]       r_word;
    logic [63:0]      r_fifo [INFLIGHT_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      r_last_popped;
    logic             r_comp_prev;
    logic             r_ack_seen;
    logic             r_found_valid;
    logic [63:0]      r_found_nonce;
    logic             r_exhausted;
    logic             r_busy;
    logic             r_err_underflow;

    logic w_active;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_hit;
    logic w_exhaust;

    assign w_active  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_empty   = (r_count == '0);
    assign w_push    = nonce_valid && nonce_ready;
    assign w_pop     = hash_pop && !w_empty && w_active;
    assign w_hit     = w_active && comp_result && !r_comp_prev;
    assign w_exhaust = (r_state == S_WAIT) && w_empty && !comp_result;

    assign job_ready     = (r_state == S_IDLE);
    assign comp_start    = (r_state == S_ARM);
    assign comp_stop     = (r_state == S_STOPPING);
    assign target_word   = (r_state == S_LOAD) ? r_target[{r_word, 5'd0} +: 32] : '0;
    assign nonce_out     = r_cur;
    assign nonce_valid   = (r_state == S_ISSUE) && (r_count < DEPTH_C);
    assign found_valid   = r_found_valid;
    assign found_nonce   = r_found_nonce;
    assign exhausted     = r_exhausted;
    assign busy          = r_busy;
    assign err_underflow = r_err_underflow;

    // A hit takes priority over abort, and abort over normal progress/exhaustion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (job_valid) w_next = S_ARM;
            S_ARM:      w_next = abort ? S_STOPPING : S_LOAD;
            S_LOAD: begin
                if (abort)              w_next = S_STOPPING;
                else if (r_word == 3'd7) w_next = r_empty_range ? S_WAIT : S_ISSUE;
            end
            S_ISSUE: begin
                if (w_hit || abort)                w_next = S_STOPPING;
                else if (w_push && r_cur == r_end) w_next = S_WAIT;
            end
            S_WAIT:     if (w_hit || abort || w_exhaust) w_next = S_STOPPING;
            S_STOPPING: if (comp_stop_ack && r_ack_seen) w_next = S_IDLE;
            default:    w_next = S_STOPPING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_cur;
    end

    // busy is registered from the next state so it reads 0 while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_STOPPING;
            r_target        <= '0;
            r_end           <= '0;
            r_cur           <= '0;
            r_empty_range   <= 1'b0;
            r_word          <= '0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_last_popped   <= '0;
            r_comp_prev     <= 1'b0;
            r_ack_seen      <= 1'b0;
            r_found_valid   <= 1'b0;
            r_found_nonce   <= '0;
            r_exhausted     <= 1'b0;
            r_busy          <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_busy        <= (w_next != S_IDLE);
            r_comp_prev   <= comp_result;
            r_found_valid <= w_hit;
            r_exhausted   <= w_exhaust && !abort;
            r_ack_seen    <= (r_state == S_STOPPING) && comp_stop_ack && (w_next == S_STOPPING);

            if (hash_pop && w_empty) r_err_underflow <= 1'b1;
            if (w_hit)               r_found_nonce   <= r_last_popped;

            if (r_state == S_IDLE && job_valid) begin
                r_target      <= job_target;
                r_end         <= job_nonce_end;
                r_cur         <= job_nonce_start;
                r_empty_range <= (job_nonce_start > job_nonce_end);
                r_found_nonce <= '0;
                r_word        <= '0;
            end

            if (r_state == S_LOAD) r_word <= r_word + 3'd1;

            // Equality-only end check: cur holds at end, so an all-ones end never wraps.
            if (r_state == S_ISSUE && w_push && r_cur != r_end) r_cur <= r_cur + 64'd1;

            if (r_state == S_STOPPING) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop) begin
                    r_rd_ptr      <= r_rd_ptr + 1'b1;
                    r_last_popped <= r_fifo[r_rd_ptr];
                end
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
